// File: rtl/icache_param.sv
// Blocking set-associative instruction cache: multi-beat refill, invalid-first + tree-PLRU
// replacement, back-to-back hits and a set-by-set invalidate walk.
module icache_param #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 128,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned BEAT_WORDS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req_i,
    input  logic [31:0]              cpu_addr_i,
    input  logic                     invalidate_i,
    output logic                     hit_o,
    output logic                     cpu_inst_valid_o,
    output logic [31:0]              cpu_inst1_o,
    output logic [31:0]              cpu_inst2_o,
    output logic                     cpu_inst2_valid_o,
    output logic                     stall_o,
    output logic                     busy_o,
    output logic                     mem_ren_o,
    input  logic                     mem_arready_i,
    output logic [31:0]              mem_araddr_o,
    input  logic                     mem_rvalid_i,
    input  logic [32*BEAT_WORDS-1:0] mem_rdata_i
);
    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
    localparam int unsigned BEATS  = LINE_WORDS / BEAT_WORDS;
    localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned LINE_W = 32 * LINE_WORDS;
    localparam int unsigned BEAT_W = 32 * BEAT_WORDS;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_WRITE, S_FLUSH} state_e;

    state_e                        state_q, state_d;
    logic [31:0]                   req_addr_q, req_addr_d;
    logic [BCNT_W-1:0]             beat_q, beat_d;
    logic [LINE_W-1:0]             line_q, line_d;
    logic                          pend_q, pend_d;
    logic [IDX_W-1:0]              flush_q, flush_d;
    logic [WAYS-1:0][SETS-1:0]     valid_q, valid_d;
    logic [SETS-1:0][PLRU_W-1:0]   plru_q, plru_d;

    logic [LINE_W-1:0] data_mem [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0] data_rd_q [WAYS];
    logic [TAG_W-1:0]  tag_rd_q  [WAYS];

    logic [IDX_W-1:0]  rd_idx, req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;
    logic              hit, found, ram_we;
    logic [WAY_W-1:0]  hit_way, victim;
    logic [LINE_W-1:0] hit_line, out_line, nxt_line;
    logic [2:0]        tree;
    logic              unused_addr_bits;

    assign rd_idx           = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign req_idx          = req_addr_q[OFF_W+IDX_W-1:OFF_W];
    assign req_tag          = req_addr_q[31:OFF_W+IDX_W];
    assign req_word         = req_addr_q[OFF_W-1:2];
    assign unused_addr_bits = ^req_addr_q[1:0];

    // Mark way w most-recently-used: each tree node is pointed away from it.
    function automatic logic [2:0] plru_touch(input logic [2:0] t, input logic [1:0] w);
        logic [2:0] n;
        n = t;
        if (WAYS == 2) begin
            n[0] = ~w[0];
        end else begin
            n[0] = ~w[1];
            if (w[1]) n[2] = ~w[0];
            else      n[1] = ~w[0];
        end
        return n;
    endfunction

    // Synchronous-read arrays, always addressed by the live fetch address.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            data_rd_q[w] <= data_mem[w][rd_idx];
            tag_rd_q[w]  <= tag_mem[w][rd_idx];
            if (ram_we && victim == WAY_W'(w)) begin
                data_mem[w][req_idx] <= line_q;
                tag_mem[w][req_idx]  <= req_tag;
            end
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && tag_rd_q[w] == req_tag) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_line = data_rd_q[w];
            end
        end
    end

    // Lowest invalid way wins; otherwise follow the PLRU tree.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        tree   = 3'(plru_q[req_idx]);
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[w][req_idx]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            if (WAYS == 2)      victim = WAY_W'(tree[0]);
            else if (WAYS == 4) victim = WAY_W'({tree[0], tree[0] ? tree[2] : tree[1]});
        end
    end

    always_comb begin
        state_d          = state_q;
        req_addr_d       = req_addr_q;
        beat_d           = beat_q;
        line_d           = line_q;
        pend_d           = pend_q;
        flush_d          = flush_q;
        valid_d          = valid_q;
        plru_d           = plru_q;
        ram_we           = 1'b0;
        hit_o            = 1'b0;
        cpu_inst_valid_o = 1'b0;
        stall_o          = 1'b0;
        busy_o           = 1'b0;
        mem_ren_o        = 1'b0;
        mem_araddr_o     = '0;
        case (state_q)
            S_IDLE: begin
                stall_o = cpu_req_i;
                if (invalidate_i || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_FLUSH;
                end else if (cpu_req_i) begin
                    req_addr_d = cpu_addr_i;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (invalidate_i) pend_d = 1'b1;
                if (hit) begin
                    hit_o            = 1'b1;
                    cpu_inst_valid_o = 1'b1;
                    plru_d[req_idx]  = PLRU_W'(plru_touch(3'(plru_q[req_idx]), 2'(hit_way)));
                    if (cpu_req_i) req_addr_d = cpu_addr_i;
                    else           state_d    = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                stall_o      = 1'b1;
                mem_ren_o    = 1'b1;
                mem_araddr_o = {req_addr_q[31:OFF_W], OFF_W'(0)};
                if (invalidate_i) pend_d = 1'b1;
                if (mem_arready_i) begin
                    beat_d  = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                stall_o = 1'b1;
                if (invalidate_i) pend_d = 1'b1;
                if (mem_rvalid_i) begin
                    line_d[beat_q*BEAT_W +: BEAT_W] = mem_rdata_i;
                    beat_d = BCNT_W'(beat_q + 1'b1);
                    if (beat_q == BCNT_W'(BEATS - 1)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cpu_inst_valid_o         = 1'b1;
                ram_we                   = 1'b1;
                valid_d[victim][req_idx] = 1'b1;
                plru_d[req_idx]          = PLRU_W'(plru_touch(3'(plru_q[req_idx]), 2'(victim)));
                if (invalidate_i) pend_d = 1'b1;
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                busy_o  = 1'b1;
                stall_o = cpu_req_i;
                for (int w = 0; w < WAYS; w++) valid_d[w][flush_q] = 1'b0;
                plru_d[flush_q] = '0;
                flush_d = IDX_W'(flush_q + 1'b1);
                if (flush_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word w and w+1 of the hit line (or the freshly filled line); the shifted copy zero-fills past the end.
    always_comb begin
        out_line          = (state_q == S_WRITE) ? line_q : hit_line;
        nxt_line          = out_line >> 32;
        cpu_inst1_o       = '0;
        cpu_inst2_o       = '0;
        cpu_inst2_valid_o = 1'b0;
        if (cpu_inst_valid_o) begin
            cpu_inst1_o       = out_line[req_word*32 +: 32];
            cpu_inst2_o       = nxt_line[req_word*32 +: 32];
            cpu_inst2_valid_o = (req_word != WORD_W'(LINE_WORDS - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            pend_q     <= 1'b0;
            flush_q    <= '0;
            valid_q    <= '0;
            plru_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            pend_q     <= pend_d;
            flush_q    <= flush_d;
            valid_q    <= valid_d;
            plru_q     <= plru_d;
        end
    end
endmodule

// File: tb/tb_icache_param.sv
// Directed + randomized bench for icache_param (default parameters) against an LRU set model
// and an address-hashed backing memory.
module tb_icache_param;
    localparam int unsigned WAYS  = 2;
    localparam int unsigned SETS  = 128;
    localparam int unsigned BEATS = 4;
    localparam int unsigned TAG_SH = 12;

    logic        clk, rst;
    logic        cpu_req_i, invalidate_i;
    logic [31:0] cpu_addr_i;
    logic        hit_o, cpu_inst_valid_o, cpu_inst2_valid_o, stall_o, busy_o, mem_ren_o;
    logic [31:0] cpu_inst1_o, cpu_inst2_o, mem_araddr_o;
    logic        mem_arready_i, mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    icache_param dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_req_i        (cpu_req_i),
        .cpu_addr_i       (cpu_addr_i),
        .invalidate_i     (invalidate_i),
        .hit_o            (hit_o),
        .cpu_inst_valid_o (cpu_inst_valid_o),
        .cpu_inst1_o      (cpu_inst1_o),
        .cpu_inst2_o      (cpu_inst2_o),
        .cpu_inst2_valid_o(cpu_inst2_valid_o),
        .stall_o          (stall_o),
        .busy_o           (busy_o),
        .mem_ren_o        (mem_ren_o),
        .mem_arready_i    (mem_arready_i),
        .mem_araddr_o     (mem_araddr_o),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] salt;

    // Model: per set, resident tags ordered most-recent first.
    int unsigned mcnt [SETS];
    logic [31:0] mtag [SETS][WAYS];

    // Results of the last fetch.
    bit          f_got, f_hit, f_v2;
    logic [31:0] f_i1, f_i2;
    int          f_lat, f_busy, f_waits;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < SETS; s++) mcnt[s] = 0;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        int          s;
        int          pos;
        logic [31:0] t;
        s   = int'((a >> 5) % SETS);
        t   = a >> TAG_SH;
        pos = -1;
        for (int i = 0; i < int'(mcnt[s]); i++) if (mtag[s][i] == t) pos = i;
        model_access = (pos >= 0);
        if (pos < 0) begin
            if (mcnt[s] < WAYS) mcnt[s]++;
            pos = int'(mcnt[s]) - 1;
        end
        for (int i = pos; i > 0; i--) mtag[s][i] = mtag[s][i-1];
        mtag[s][0] = t;
    endfunction

    // One fetch acting as both CPU and memory bridge. inv_mode: -1 none, -2 with the request,
    // k >= 0 alongside beat k. abort_after >= 0 leaves once that beat has been delivered.
    task automatic fetch(input logic [31:0] a, input int inv_mode, input int abort_after);
        int          beat;
        bit          ar_done, ar_chk;
        logic [31:0] base;
        beat = 0; ar_done = 0; ar_chk = 0; base = a & ~32'h1F;
        f_got = 0; f_hit = 0; f_i1 = 0; f_i2 = 0; f_v2 = 0; f_lat = 0; f_busy = 0; f_waits = 0;
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        if (inv_mode == -2) invalidate_i = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            invalidate_i  = 1'b0;
            mem_arready_i = 1'b0;
            mem_rvalid_i  = 1'b0;
            f_lat++;
            if (busy_o) begin
                f_busy++;
                chk("flush_stall", 64'(stall_o), 64'(1));
            end
            if (cpu_inst_valid_o) begin
                f_got = 1; f_hit = hit_o; f_i1 = cpu_inst1_o; f_i2 = cpu_inst2_o; f_v2 = cpu_inst2_valid_o;
                cpu_req_i = 1'b0;
                break;
            end
            if (abort_after >= 0 && beat > abort_after) break;
            if (mem_ren_o && !ar_done) begin
                if (!ar_chk) begin
                    chk("araddr", 64'(mem_araddr_o), 64'(base));
                    ar_chk = 1;
                end
                if ($urandom_range(0, 2) == 0) f_waits++;
                else begin
                    mem_arready_i = 1'b1;
                    ar_done       = 1;
                end
            end else if (ar_done && beat < int'(BEATS)) begin
                if ($urandom_range(0, 3) == 0) f_waits++;
                else begin
                    if (inv_mode == beat) invalidate_i = 1'b1;
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = {mem_word(base + 32'(8*beat) + 32'd4), mem_word(base + 32'(8*beat))};
                    beat++;
                end
            end
        end
        if (abort_after < 0) chk("fetch_done", 64'(f_got), 64'(1));
    endtask

    task automatic fetch_chk(input logic [31:0] a, input int inv_mode, input bit exp_flush);
        bit exp_hit;
        bit last;
        if (inv_mode == -2) model_flush();
        exp_hit = model_access(a);
        last    = (a[4:2] == 3'd7);
        fetch(a, inv_mode, -1);
        chk("hit", 64'(f_hit), 64'(exp_hit));
        chk("inst1", 64'(f_i1), 64'(mem_word(a)));
        chk("inst2", 64'(f_i2), 64'(last ? 32'h0 : mem_word(a + 32'd4)));
        chk("inst2_valid", 64'(f_v2), 64'(!last));
        if (exp_flush) chk("flush_cycles", 64'(f_busy), 64'(SETS));
        else           chk("latency", 64'(f_lat), 64'(exp_hit ? 1 : 3 + int'(BEATS) + f_waits));
        if (inv_mode >= 0) model_flush();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, 64'({hit_o, cpu_inst_valid_o, cpu_inst2_valid_o, stall_o, busy_o, mem_ren_o}), 64'(0));
        chk({tag, "_data"}, {cpu_inst1_o, cpu_inst2_o}, 64'(0));
        chk({tag, "_araddr"}, 64'(mem_araddr_o), 64'(0));
    endtask

    initial begin
        logic [31:0] a;
        bit          eh;
        rst = 1'b1; cpu_req_i = 1'b0; cpu_addr_i = '0; invalidate_i = 1'b0;
        mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        salt = $urandom;
        model_flush();
        #1 chk_quiet("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk_quiet("post_reset");

        // Cold miss, then the same address hits one cycle after the request.
        fetch_chk(32'h0000_1004, -1, 0);
        fetch_chk(32'h0000_1004, -1, 0);

        // Back-to-back hits on consecutive cycles.
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_1000;
        #1 chk("b2b_stall_idle", 64'(stall_o), 64'(1));
        for (int i = 0; i < 3; i++) begin
            a  = 32'h0000_1000 + 32'(8*i);
            eh = model_access(a);
            @(negedge clk);
            chk("b2b_valid", 64'(cpu_inst_valid_o), 64'(1));
            chk("b2b_hit", 64'(hit_o), 64'(eh));
            chk("b2b_stall", 64'(stall_o), 64'(0));
            chk("b2b_inst1", 64'(cpu_inst1_o), 64'(mem_word(a)));
            if (i < 2) cpu_addr_i = a + 32'd8;
            else       cpu_req_i  = 1'b0;
        end

        // Last word of a line, then three tags competing for set 0.
        fetch_chk(32'h0000_101C, -1, 0);
        fetch_chk(32'h0000_3000, -1, 0);
        fetch_chk(32'h0000_5000, -1, 0);
        fetch_chk(32'h0000_3000, -1, 0);
        fetch_chk(32'h0000_1000, -1, 0);

        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2);
            fetch_chk(a, -1, 0);
        end

        // Invalidate during beat 2 completes the fill, then the walk runs before the next lookup.
        fetch_chk(32'h0000_9004, 2, 0);
        fetch_chk(32'h0000_1004, -1, 1);
        // Invalidate together with a request in IDLE: flush first, then serve it.
        fetch_chk(32'h0000_2008, -2, 1);

        // Async reset in the middle of a refill; stray beats afterwards are ignored.
        void'(model_access(32'h0000_6004));
        fetch(32'h0000_6004, -1, 1);
        model_flush();
        #2;
        rst = 1'b1; cpu_req_i = 1'b0;
        #1 chk_quiet("mid_refill_reset");
        mem_rvalid_i = 1'b1; mem_rdata_i = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_beat_valid", 64'(cpu_inst_valid_o), 64'(0));
            chk("stray_beat_stall", 64'(stall_o), 64'(0));
        end
        mem_rvalid_i = 1'b0;
        fetch_chk(32'h0000_1004, -1, 0);
        fetch_chk(32'h0000_6004, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
